// File: rtl/ip_stride_pkg.sv
// Shared types and constants for the IP-indexed stride prefetcher.
package ip_stride_pkg;

  localparam int unsigned CONF_W     = 2;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned PAGE_SHIFT = 12;
  localparam logic [CONF_W-1:0] CONF_MAX = 2'd3;

  // The tag is kept at full address width (ip >> IDX_W); its unused upper
  // bits are always zero, so the package does not depend on table size.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] stride;
    logic [CONF_W-1:0] conf;
  } tracker_entry_t;

endpackage

// File: rtl/stride_entry_update.sv
// Combinational next-state and prefetch generation for one tracker entry.
// Optional macro STRIDE_PAGE_BOUND_EN suppresses slots that leave the 4 KiB page.
module stride_entry_update
  import ip_stride_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  tracker_entry_t              cur,
  input  logic [ADDR_W-1:0]           ip,
  input  logic [ADDR_W-1:0]           addr,
  output tracker_entry_t              nxt,
  output logic [2:0]                  pref_valid,
  output logic [2:0][ADDR_W-1:0]      pref_addr
);

  logic [ADDR_W-1:0]      tag;
  logic [ADDR_W-1:0]      new_stride;
  logic                   hit;
  logic [2:0][ADDR_W-1:0] cand;
  logic [2:0]             slot_ok;

  always_comb begin
    tag        = ip >> IDX_W;
    hit        = cur.valid && (cur.tag == tag);
    new_stride = addr - cur.last_addr;

    // Miss allocation is the default; a hit only refines stride and conf.
    nxt           = '0;
    nxt.valid     = 1'b1;
    nxt.tag       = tag;
    nxt.last_addr = addr;
    if (hit) begin
      if ((new_stride == cur.stride) && (cur.stride != '0)) begin
        nxt.stride = cur.stride;
        nxt.conf   = (cur.conf == CONF_MAX) ? CONF_MAX : cur.conf + 1'b1;
      end else begin
        nxt.stride = new_stride;
      end
    end

    cand[0] = addr + nxt.stride;
    cand[1] = addr + (nxt.stride << 1);
    cand[2] = cand[1] + nxt.stride;

    slot_ok = {nxt.conf == CONF_MAX, nxt.conf >= 2'd2, nxt.conf != '0};
`ifdef STRIDE_PAGE_BOUND_EN
    for (int unsigned k = 0; k < 3; k++) begin
      if (cand[k][ADDR_W-1:PAGE_SHIFT] != addr[ADDR_W-1:PAGE_SHIFT]) slot_ok[k] = 1'b0;
    end
`endif

    pref_valid = slot_ok;
    for (int unsigned k = 0; k < 3; k++) begin
      pref_addr[k] = slot_ok[k] ? cand[k] : '0;
    end
  end

endmodule

// File: rtl/ip_stride_prefetcher.sv
// IP-indexed stride prefetcher: direct-mapped tracker table plus registered prefetch outputs.
// Optional macro STRIDE_PAGE_BOUND_EN enables 4 KiB page-crossing suppression.
module ip_stride_prefetcher
  import ip_stride_pkg::*;
#(
  parameter int unsigned IP_TRACKER_COUNT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] addr_i,
  input  logic [63:0] ip_i,
  output logic [63:0] pref_addr1_o,
  output logic        pref_valid1_o,
  output logic [63:0] pref_addr2_o,
  output logic        pref_valid2_o,
  output logic [63:0] pref_addr3_o,
  output logic        pref_valid3_o
);

  localparam int unsigned IDX_W = $clog2(IP_TRACKER_COUNT);

  tracker_entry_t         trk_q [IP_TRACKER_COUNT];
  tracker_entry_t         cur;
  tracker_entry_t         nxt;
  logic [IDX_W-1:0]       idx;
  logic [2:0]             pref_valid;
  logic [2:0][ADDR_W-1:0] pref_addr;

  always_comb begin
    idx = ip_i[IDX_W-1:0];
    cur = trk_q[idx];
  end

  stride_entry_update #(
    .IDX_W (IDX_W)
  ) u_update (
    .cur        (cur),
    .ip         (ip_i),
    .addr       (addr_i),
    .nxt        (nxt),
    .pref_valid (pref_valid),
    .pref_addr  (pref_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < IP_TRACKER_COUNT; i++) trk_q[i] <= '0;
      pref_valid1_o <= 1'b0;
      pref_valid2_o <= 1'b0;
      pref_valid3_o <= 1'b0;
      pref_addr1_o  <= '0;
      pref_addr2_o  <= '0;
      pref_addr3_o  <= '0;
    end else begin
      trk_q[idx]    <= nxt;
      pref_valid1_o <= pref_valid[0];
      pref_valid2_o <= pref_valid[1];
      pref_valid3_o <= pref_valid[2];
      pref_addr1_o  <= pref_addr[0];
      pref_addr2_o  <= pref_addr[1];
      pref_addr3_o  <= pref_addr[2];
    end
  end

endmodule

// File: tb/tb_ip_stride_prefetcher.sv
// Scoreboard bench for ip_stride_prefetcher; honours STRIDE_PAGE_BOUND_EN when defined.
module tb_ip_stride_prefetcher;

  logic        clk;
  logic        rst;
  logic [63:0] addr_i;
  logic [63:0] ip_i;
  logic [63:0] pref_addr1_o, pref_addr2_o, pref_addr3_o;
  logic        pref_valid1_o, pref_valid2_o, pref_valid3_o;

  ip_stride_prefetcher #(.IP_TRACKER_COUNT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr_i        (addr_i),
    .ip_i          (ip_i),
    .pref_addr1_o  (pref_addr1_o),
    .pref_valid1_o (pref_valid1_o),
    .pref_addr2_o  (pref_addr2_o),
    .pref_valid2_o (pref_valid2_o),
    .pref_addr3_o  (pref_addr3_o),
    .pref_valid3_o (pref_valid3_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       v;
    logic [2:0][63:0] a;
  } exp_t;

  exp_t sb_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference tracker table, 64 entries, index = ip[5:0]
  logic        m_valid  [64];
  logic [63:0] m_tag    [64];
  logic [63:0] m_last   [64];
  logic [63:0] m_stride [64];
  int          m_conf   [64];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_last[i] = '0; m_stride[i] = '0; m_conf[i] = 0;
    end
  endfunction

  function automatic exp_t model_step(input logic [63:0] ip, input logic [63:0] addr);
    exp_t        e;
    int          idx = int'(ip[5:0]);
    logic [63:0] tag = ip >> 6;
    logic [63:0] ns;
    logic [63:0] cand;
    logic        ok;
    if (!m_valid[idx] || m_tag[idx] != tag) begin
      m_valid[idx] = 1'b1; m_tag[idx] = tag; m_stride[idx] = '0; m_conf[idx] = 0;
    end else begin
      ns = addr - m_last[idx];
      if (ns == m_stride[idx] && ns != 64'd0) begin
        if (m_conf[idx] < 3) m_conf[idx]++;
      end else begin
        m_stride[idx] = ns; m_conf[idx] = 0;
      end
    end
    m_last[idx] = addr;
    for (int k = 1; k <= 3; k++) begin
      cand = addr + 64'(k) * m_stride[idx];
      ok   = (m_conf[idx] >= k);
`ifdef STRIDE_PAGE_BOUND_EN
      if (cand[63:12] != addr[63:12]) ok = 1'b0;
`endif
      e.v[k-1] = ok;
      e.a[k-1] = ok ? cand : 64'd0;
    end
    return e;
  endfunction

  task automatic access(input logic [63:0] ip, input logic [63:0] addr);
    exp_t e;
    sb_q.push_back(model_step(ip, addr));
    ip_i   = ip;
    addr_i = addr;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check("valid1", {63'd0, pref_valid1_o}, {63'd0, e.v[0]});
      check("valid2", {63'd0, pref_valid2_o}, {63'd0, e.v[1]});
      check("valid3", {63'd0, pref_valid3_o}, {63'd0, e.v[2]});
      check("addr1", pref_addr1_o, e.a[0]);
      check("addr2", pref_addr2_o, e.a[1]);
      check("addr3", pref_addr3_o, e.a[2]);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_v"}, {61'd0, pref_valid3_o, pref_valid2_o, pref_valid1_o}, 64'd0);
    check({tag, "_a1"}, pref_addr1_o, 64'd0);
    check({tag, "_a2"}, pref_addr2_o, 64'd0);
    check({tag, "_a3"}, pref_addr3_o, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [63:0] r_addr   [16];
  logic [63:0] r_stride [16];

  initial begin
    logic [63:0] a;
    int unsigned sel;

    rst = 1'b0; ip_i = '0; addr_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    rst = 1'b1;

    // Single IP, stride 100
    for (int i = 0; i < 5; i++) begin
      access(64'd5, 64'(1000 + 100 * i));
      if (i == 2) begin
        check("sip3_v", {61'd0, pref_valid3_o, pref_valid2_o, pref_valid1_o}, 64'b001);
        check("sip3_a1", pref_addr1_o, 64'd1300);
      end
      if (i == 3) check("sip4_a2", pref_addr2_o, 64'd1500);
      if (i == 4) begin
        check("sip5_v", {61'd0, pref_valid3_o, pref_valid2_o, pref_valid1_o}, 64'b111);
        check("sip5_a3", pref_addr3_o, 64'd1700);
      end
    end

    // Stride break then re-learn
    access(64'd5, 64'd1700);
    check("brk_v", {61'd0, pref_valid3_o, pref_valid2_o, pref_valid1_o}, 64'b000);
    access(64'd5, 64'd2000);
    check("brk2_v", {61'd0, pref_valid3_o, pref_valid2_o, pref_valid1_o}, 64'b001);
    check("brk2_a1", pref_addr1_o, 64'd2300);

    // Interleaved IPs, per-IP stride 570
    for (int c = 0; c < 60; c++) begin
      a = 64'h2_0000 + 64'(57 * c);
      access(64'(32 + c % 10), a);
      if (c == 25) check("ilv_v1", {63'd0, pref_valid1_o}, 64'd1);
      if (c == 41) begin
        check("ilv_v3", {63'd0, pref_valid3_o}, 64'd1);
        check("ilv_a3", pref_addr3_o, a + 64'd1710);
      end
    end

    // Aliasing IPs thrash one entry
    for (int i = 0; i < 8; i++) begin
      access((i % 2 == 1) ? 64'd67 : 64'd3, 64'(5000 + 100 * i));
      check("alias_v", {61'd0, pref_valid3_o, pref_valid2_o, pref_valid1_o}, 64'd0);
    end

    // Negative stride wrapping below zero
    access(64'd7, 64'd16);
    access(64'd7, 64'd8);
    access(64'd7, 64'd0);
`ifdef STRIDE_PAGE_BOUND_EN
    check("wrap_v1", {63'd0, pref_valid1_o}, 64'd0);
    check("wrap_a1", pref_addr1_o, 64'd0);
`else
    check("wrap_v1", {63'd0, pref_valid1_o}, 64'd1);
    check("wrap_a1", pref_addr1_o, 64'hFFFF_FFFF_FFFF_FFF8);
`endif

    // Mid-stream asynchronous reset
    for (int i = 0; i < 5; i++) access(64'd9, 64'h3000 + 64'(64 * i));
    rst = 1'b0;
    #1;
    check_idle("midrst");
    model_reset();
    @(posedge clk);
    #1;
    check_idle("midrst_hold");
    rst = 1'b1;
    access(64'd9, 64'h3140);
    check("postrst_v", {61'd0, pref_valid3_o, pref_valid2_o, pref_valid1_o}, 64'd0);

    // Random mix of strided streams with occasional jumps and aliasing
    for (int i = 0; i < 16; i++) begin
      r_addr[i]   = {$urandom, $urandom};
      r_stride[i] = 64'(i * 8 - 40);
    end
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) r_addr[sel] = {$urandom, $urandom};
      else                           r_addr[sel] = r_addr[sel] + r_stride[sel];
      access(64'(100 + sel + (($urandom_range(0, 9) == 0) ? 64 : 0)), r_addr[sel]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
